serial_frame_tx: RTL

Serial frame transmitter: the sending end of the team's single-wire serial link. Accepts a frame request (destination port, payload length, payload word) over a valid/ready handshake and drives the serial line: idle-high, one start bit, 8-bit header, payload bits, then stop bits. Sits between the test/host-side register logic and the `sin` input of the link receiver, whose port demux and length counter consume the header this block emits.

---
 rtl/serial_link_pkg.sv | 23 ++
 rtl/serial_piso.sv | 27 ++
 rtl/serial_frame_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: header layout and FSM state encoding shared by both ends of the serial link.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HDR   = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int HDR_BITS  = 8;
    localparam int PORT_W    = 2;
    localparam int LEN_W     = 6;
    localparam int DATA_BITS = 64;

    // Header byte: payload length in the upper six bits, destination port in the lower two.
    function automatic logic [HDR_BITS-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                     input logic [PORT_W-1:0] port);
        return {len, port};
    endfunction

endpackage

// File: rtl/serial_piso.sv
// serial_piso: load/shift parallel-in serial-out register; bit 0 is the next bit to leave.
module serial_piso #(
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] r_sreg;

    // Parallel load has priority; otherwise shift right towards bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sreg <= '0;
        else if (load)
            r_sreg <= din;
        else if (shift)
            r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
    end

    assign dout = r_sreg[0];

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: drives one frame per accepted request onto the idle-high serial line:
// start bit, 8-bit header MSB first, payload LSB first, then STOP_CYCLES stop bits.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int STOP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PORT_W-1:0]    req_port,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [DATA_BITS-1:0] req_data,
    input  logic                 abort,
    output logic                 sout,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2:0]           cur_state
);

    localparam int         PISO_W    = HDR_BITS + DATA_BITS;
    localparam logic [2:0] STOP_LAST = 3'(STOP_CYCLES - 1);

    state_t             r_state, w_next;
    logic [2:0]         r_hcnt, w_hcnt_next;
    logic [LEN_W-1:0]   r_dcnt, w_dcnt_next;
    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_scnt, w_scnt_next;
    logic               r_abt, w_abt_next;     // current frame was cut short by abort
    logic               r_sout, r_done, r_aborted;
    logic               w_accept, w_abort_take, w_shift;
    logic               w_sout_next, w_done_next;
    logic               w_piso_bit;
    logic [HDR_BITS-1:0] w_hdr;
    logic [PISO_W-1:0]  w_load_word;

    // Header goes out MSB first through a right-shifting register, so store it bit-reversed below the payload.
    always_comb begin
        w_hdr       = hdr_pack(req_len, req_port);
        w_load_word = {req_data, {HDR_BITS{1'b0}}};
        for (int i = 0; i < HDR_BITS; i++)
            w_load_word[i] = w_hdr[HDR_BITS-1-i];
    end

    serial_piso #(.WIDTH(PISO_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_shift),
        .din   (w_load_word),
        .dout  (w_piso_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and counter updates; abort beats the normal HDR/DATA exits.
    always_comb begin
        w_next       = r_state;
        w_hcnt_next  = r_hcnt;
        w_dcnt_next  = r_dcnt;
        w_scnt_next  = r_scnt;
        w_abort_take = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = START;
                end
            end
            START: begin
                w_next      = HDR;
                w_hcnt_next = 3'd0;
            end
            HDR: begin
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_next       = STOP;
                    w_scnt_next  = 3'd0;
                end else if (r_hcnt == 3'd7) begin
                    if (r_len != '0) begin
                        w_next      = DATA;
                        w_dcnt_next = r_len;
                    end else begin
                        w_next      = STOP;
                        w_scnt_next = 3'd0;
                    end
                end else begin
                    w_hcnt_next = r_hcnt + 3'd1;
                end
            end
            DATA: begin
                if (abort) begin
                    w_abort_take = 1'b1;
                    w_next       = STOP;
                    w_scnt_next  = 3'd0;
                end else if (r_dcnt == 6'd1) begin
                    w_next      = STOP;
                    w_scnt_next = 3'd0;
                end else begin
                    w_dcnt_next = r_dcnt - 6'd1;
                end
            end
            STOP: begin
                if (r_scnt == STOP_LAST)
                    w_next = IDLE;
                else
                    w_scnt_next = r_scnt + 3'd1;
            end
            default: w_next = IDLE;
        endcase
        w_abt_next = w_accept ? 1'b0 : (w_abort_take ? 1'b1 : r_abt);
    end

    // Output decode: handshake/debug from the state register, line value for the upcoming cycle from next state.
    always_comb begin
        req_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        cur_state = r_state;
        w_shift   = (w_next == HDR) || (w_next == DATA);
        unique case (w_next)
            START:     w_sout_next = 1'b0;
            HDR, DATA: w_sout_next = w_piso_bit;
            default:   w_sout_next = 1'b1;
        endcase
        w_done_next = (w_next == STOP) && (w_scnt_next == STOP_LAST) && !w_abt_next;
    end

    // Frame bookkeeping: latched length, bit counters and abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len  <= '0;
            r_hcnt <= '0;
            r_dcnt <= '0;
            r_scnt <= '0;
            r_abt  <= 1'b0;
        end else begin
            if (w_accept)
                r_len <= req_len;
            r_hcnt <= w_hcnt_next;
            r_dcnt <= w_dcnt_next;
            r_scnt <= w_scnt_next;
            r_abt  <= w_abt_next;
        end
    end

    // Registered line and status pulses; the line idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sout    <= 1'b1;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_sout    <= w_sout_next;
            r_done    <= w_done_next;
            r_aborted <= w_abort_take;
        end
    end

    assign sout    = r_sout;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule
